dmem_responder: RTL and testbench

- Memory-side responder for the core's data-load/store interface.
- Accepts one request at a time on a valid/ready request channel.
- Models a configurable access latency, then performs the byte/half/word access on an internal word-organised RAM.
- Returns read data or a completion on a valid/ready response channel with backpressure. It is the slave end for a future multi-cycle core/bus initiator.

---
 rtl/dmem_responder_if.sv | 27 ++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response channel pair between a data-load/store initiator and the memory responder.
// Both channels use valid/ready; the initiator owns req_* payload and rsp_ready.
interface dmem_responder_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data memory responder: byte/half/word access on a word RAM, rsp_valid LATENCY cycles after accept.
// Response is held stable under rsp_ready backpressure; no new request is accepted until the response handshakes.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic            write;
    logic [XLEN-1:0] addr;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  req_t            req_q, req_in, cur;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            accept, enter_resp, leave_resp;

  logic [31:0]     ram [DEPTH_WORDS];
  logic [AW-1:0]   word_idx;
  logic [31:0]     cur_word, wword;
  logic [3:0]      wmask;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;
  logic            acc_err;

  always_comb begin
    req_in = '{write: bus.req_write, addr: bus.req_addr, size: bus.req_size,
               uns: bus.req_unsigned, wdata: bus.req_wdata};
  end

  // With LATENCY==1 the access happens on the accept edge, before req_q holds the request.
  assign cur      = (state_q == IDLE) ? req_in : req_q;
  assign word_idx = cur.addr[AW+1:2];
  assign cur_word = ram[word_idx];

  always_comb begin
    acc_err = 1'b0;
    if (cur.size == 2'b11)                            acc_err = 1'b1;
    if (cur.size == 2'b01 && cur.addr[0])             acc_err = 1'b1;
    if (cur.size == 2'b10 && cur.addr[1:0] != 2'b00)  acc_err = 1'b1;
    if ((cur.addr[XLEN-1:2] >> AW) != '0)             acc_err = 1'b1;
  end

  always_comb begin
    ld_byte = cur_word[{cur.addr[1:0], 3'b000} +: 8];
    ld_half = cur_word[{cur.addr[1], 4'b0000} +: 16];
    ld_val  = '0;
    wword   = cur.wdata[31:0];
    wmask   = 4'b0000;
    case (cur.size)
      2'b00: begin
        ld_val = cur.uns ? {{(XLEN-8){1'b0}}, ld_byte} : {{(XLEN-8){ld_byte[7]}}, ld_byte};
        wword  = {4{cur.wdata[7:0]}};
        wmask  = 4'b0001 << cur.addr[1:0];
      end
      2'b01: begin
        ld_val = cur.uns ? {{(XLEN-16){1'b0}}, ld_half} : {{(XLEN-16){ld_half[15]}}, ld_half};
        wword  = {2{cur.wdata[15:0]}};
        wmask  = cur.addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        ld_val = cur_word;
        wmask  = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_d  = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d    = IDLE;
          leave_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rdata_q <= (acc_err || cur.write) ? '0 : ld_val;
        err_q   <= acc_err;
      end else if (leave_resp) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_q <= req_in;
  end

  // RAM has no reset; a store commits only on the RESP-entry edge.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur.write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 2, 4, 1) against a byte-array memory model with random and directed traffic.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmem_responder;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  int          sel;
  logic        req_valid, req_write, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        s_req_ready, s_rsp_valid, s_rsp_error;
  logic [31:0] s_rsp_rdata;
  int          cyc = 0;
  int          n_tests = 0, n_fail = 0;
  int          acc_cyc;
  int          lat_of [3] = '{2, 4, 1};
  logic [7:0]  m [3][4*DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.XLEN(32)) b0 ();
  dmem_responder_if #(.XLEN(32)) b1 ();
  dmem_responder_if #(.XLEN(32)) b2 ();

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(b0));
  dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(b1));
  dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.req_valid = req_valid && (sel == 0);
  assign b1.req_valid = req_valid && (sel == 1);
  assign b2.req_valid = req_valid && (sel == 2);
  assign {b0.req_write, b1.req_write, b2.req_write}          = {3{req_write}};
  assign {b0.req_unsigned, b1.req_unsigned, b2.req_unsigned} = {3{req_unsigned}};
  assign {b0.req_size, b1.req_size, b2.req_size}             = {3{req_size}};
  assign {b0.req_addr, b1.req_addr, b2.req_addr}             = {3{req_addr}};
  assign {b0.req_wdata, b1.req_wdata, b2.req_wdata}          = {3{req_wdata}};
  assign {b0.rsp_ready, b1.rsp_ready, b2.rsp_ready}          = {3{rsp_ready}};

  always_comb begin
    case (sel)
      1:       {s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_error} = {b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.rsp_error};
      2:       {s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_error} = {b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.rsp_error};
      default: {s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_error} = {b0.req_ready, b0.rsp_valid, b0.rsp_rdata, b0.rsp_error};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, cycle %0d): got %h expected %h", tag, sel, cyc, got, exp);
    end
  endtask

  // One complete transaction on the selected DUT; starts and ends on a falling edge.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [1:0] sz, input bit u,
                     input logic [31:0] wd, input int hold);
    int          nb = 1 << sz;
    bit          exp_err;
    logic [31:0] exp_rd = '0;
    logic [31:0] rd;
    logic        er;
    int          n = 0;
    int          j = 0;
    exp_err = (sz == 2'b11) || ((a % nb) != 0) || (a >= 32'(4*DEPTH));
    if (!exp_err && !wr) begin
      for (int i = 0; i < nb; i++) exp_rd |= 32'(m[sel][a+i]) << (8*i);
      if (nb < 4 && !u && exp_rd[8*nb-1]) exp_rd |= 32'hFFFF_FFFF << (8*nb);
    end
    req_write = wr; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1;
    while (!s_req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    while (!s_rsp_valid && j < 40) begin @(negedge clk); j++; end
    chk("latency", 64'(j + 1), 64'(lat_of[sel]));
    if (j >= 40) return;
    rd = s_rsp_rdata; er = s_rsp_error;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("hold_stable", {s_rsp_valid, s_req_ready, s_rsp_rdata, s_rsp_error}, {1'b1, 1'b0, rd, er});
      end
      rsp_ready = 1'b1;
    end
    chk("rdata", rd, exp_rd);
    chk("error", er, exp_err);
    @(negedge clk);
    chk("after_handshake", {s_rsp_valid, s_req_ready, s_rsp_rdata, s_rsp_error}, {1'b1 ^ 1'b1, 1'b1, 32'h0, 1'b0});
    if (wr && !exp_err)
      for (int i = 0; i < nb; i++) m[sel][a+i] = wd[8*i +: 8];
  endtask

  initial begin
    int prev;
    bit seen;
    rst = 1'b1; sel = 0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_write = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk("reset_outputs", {s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_error}, 35'h0);
    end
    rst = 1'b0;
    #1;
    chk("ready_after_reset", s_req_ready, 1);
    sel = 0;
    @(negedge clk);

    // Give every model byte a known value before any load.
    for (int d = 0; d < 3; d++) begin
      sel = d;
      for (int w = 0; w < DEPTH; w++) txn(1'b1, 32'(4*w), 2'b10, 1'b0, $urandom, 0);
    end

    sel = 0;
    txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    txn(1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_0080, 0);
    txn(1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 0);
    txn(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0);
    txn(1'b1, 32'h13, 2'b01, 1'b0, 32'h5555_AAAA, 0);
    txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h4002, 2'b10, 1'b0, 32'h0, 0);
    txn(1'b0, 32'(4*DEPTH), 2'b10, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h8, 2'b11, 1'b0, 32'h0, 0);
    txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5);

    // Store accepted, then reset while it is still waiting.
    sel = 1;
    req_write = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", s_req_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_wait_reset", s_req_ready, 1);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (s_rsp_valid) seen = 1'b1; end
    chk("no_rsp_after_reset", seen, 0);
    txn(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 0);

    sel = 2;
    txn(1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 0);
    prev = acc_cyc;
    for (int k = 1; k < 6; k++) begin
      txn(1'b0, 32'(4*k), 2'b10, 1'b0, 32'h0, 0);
      chk("b2b_spacing", 64'(acc_cyc - prev), 64'd2);
      prev = acc_cyc;
    end

    for (int d = 0; d < 3; d++) begin
      sel = d;
      for (int k = 0; k < 60; k++)
        txn(1'($urandom), 32'($urandom_range(0, 4*DEPTH + 7)), 2'($urandom), 1'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
